ofmap_writeback: RTL and testbench

- Consumer end of the PE-group result interface.
- Accepts 11-bit signed group sums qualified by wb_en. Clamps each sum to int8, packs four bytes per 32-bit word and writes the words into the ofmap SRAM at consecutive word addresses.
- Detects end of stream (wb_en falling edge or expected count reached), flushes any partial word and signals completion to the layer controller.

---
 rtl/ofmap_writeback.sv | 165 ++++++++++++++++
 tb/tb_ofmap_writeback.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofmap_writeback.sv
// Ofmap writeback: clamps PE-group sums to int8, packs four per word and writes them to the ofmap SRAM.
// Optional macro WB_RELU_EN applies ReLU before the upper clamp.
module ofmap_writeback #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [3:0]               layer,
  input  logic [ADDR_W-1:0]        cfg_base,
  input  logic [CNT_W-1:0]         cfg_num_out,
  input  logic                     wb_en,
  input  logic signed [10:0]       groupsum_in1,
  input  logic signed [10:0]       groupsum_in2,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_wstrb,
  output logic                     busy,
  output logic                     done,
  output logic                     sat_flag
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t            state, state_nx;
  logic [2:0]        fill;
  logic [CNT_W-1:0]  cnt, num_out;
  logic              single, wb_en_d;
  logic [31:0]       pack_p0;

  logic              accept, full, end_cond, sat_acc;
  logic [1:0]        take;
  logic [2:0]        fill_acc;
  logic [CNT_W-1:0]  cnt_acc;
  logic [31:0]       pack_acc;
  logic [3:0]        flush_strb;
  logic [7:0]        byte1, byte2;

  function automatic logic [7:0] clamp8(input logic signed [10:0] v);
`ifdef WB_RELU_EN
    if (v < 0)        return 8'h00;
    else if (v > 127) return 8'h7F;
    else              return v[7:0];
`else
    if (v > 127)       return 8'h7F;
    else if (v < -128) return 8'h80;
    else               return v[7:0];
`endif
  endfunction

  function automatic logic is_sat(input logic signed [10:0] v);
`ifdef WB_RELU_EN
    return (v > 127);
`else
    return (v > 127) || (v < -128);
`endif
  endfunction

  assign byte1 = clamp8(groupsum_in1);
  assign byte2 = clamp8(groupsum_in2);
  assign busy  = (state == RUN) || (state == FLUSH);

  always_comb begin
    accept     = (state == RUN) && wb_en;
    take       = 2'd0;
    pack_acc   = pack_p0;
    sat_acc    = 1'b0;
    flush_strb = 4'b0000;
    state_nx   = state;
    if (accept) begin
      // the last beat of an odd dual-lane count only carries lane 1
      if (single || (num_out != '0 && (num_out - cnt) == CNT_W'(1)))
        take = 2'd1;
      else
        take = 2'd2;
    end
    fill_acc = fill + {1'b0, take};
    cnt_acc  = cnt + CNT_W'(take);
    if (take != 2'd0) begin
      pack_acc[8*fill[1:0] +: 8] = byte1;
      sat_acc = is_sat(groupsum_in1);
    end
    if (take == 2'd2) begin
      pack_acc[8*(fill[1:0] + 2'd1) +: 8] = byte2;
      sat_acc = sat_acc | is_sat(groupsum_in2);
    end
    full     = (fill_acc == 3'd4);
    end_cond = (state == RUN) &&
               ((wb_en_d && !wb_en) || (accept && num_out != '0 && cnt_acc == num_out));
    case (fill)
      3'd1:    flush_strb = 4'b0001;
      3'd2:    flush_strb = 4'b0011;
      3'd3:    flush_strb = 4'b0111;
      default: flush_strb = 4'b0000;
    endcase
    case (state)
      IDLE:  state_nx = IDLE;
      RUN:   if (end_cond) state_nx = (full || fill_acc == 3'd0) ? DONE : FLUSH;
      FLUSH: state_nx = DONE;
      DONE:  state_nx = DONE;
      default: state_nx = IDLE;
    endcase
    if (start) state_nx = RUN;
  end

  // p0: byte packing buffer (data only, no reset)
  always_ff @(posedge clk) begin
    if (accept && !start) pack_p0 <= pack_acc;
  end

  // control and SRAM write port registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      fill      <= '0;
      cnt       <= '0;
      num_out   <= '0;
      single    <= 1'b0;
      wb_en_d   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      done      <= 1'b0;
      sat_flag  <= 1'b0;
    end else begin
      state   <= state_nx;
      wb_en_d <= start ? 1'b0 : wb_en;
      done    <= !start && (state == DONE);
      mem_we  <= 1'b0;
      if (start) begin
        fill     <= '0;
        cnt      <= '0;
        sat_flag <= 1'b0;
        mem_addr <= cfg_base;
        num_out  <= cfg_num_out;
        single   <= (layer == 4'd1);
      end else begin
        if (mem_we) mem_addr <= mem_addr + ADDR_W'(1);
        if (accept) begin
          cnt      <= cnt_acc;
          sat_flag <= sat_flag | sat_acc;
          if (full) begin
            mem_we    <= 1'b1;
            mem_wdata <= pack_acc;
            mem_wstrb <= 4'b1111;
            fill      <= '0;
          end else begin
            fill <= fill_acc;
          end
        end
        if (state == FLUSH) begin
          mem_we    <= 1'b1;
          mem_wdata <= pack_p0 & {{8{flush_strb[3]}}, {8{flush_strb[2]}},
                                  {8{flush_strb[1]}}, {8{flush_strb[0]}}};
          mem_wstrb <= flush_strb;
          fill      <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ofmap_writeback.sv
// Scoreboard bench for ofmap_writeback: expected SRAM writes are queued with stimulus and popped by a write monitor.
module tb_ofmap_writeback;
  localparam int ADDR_W = 10;
  localparam int CNT_W  = 16;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, wb_en = 1'b0;
  logic [3:0] layer = '0;
  logic [ADDR_W-1:0] cfg_base = '0;
  logic [CNT_W-1:0] cfg_num_out = '0;
  logic signed [10:0] groupsum_in1 = '0, groupsum_in2 = '0;
  logic mem_we, busy, done, sat_flag;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0] mem_wstrb;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [3:0]        strb;
  } wr_t;
  wr_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  ofmap_writeback #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .layer(layer), .cfg_base(cfg_base),
    .cfg_num_out(cfg_num_out), .wb_en(wb_en), .groupsum_in1(groupsum_in1),
    .groupsum_in2(groupsum_in2), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .busy(busy), .done(done),
    .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: actual addr=%h data=%h strb=%b required=no write",
                 mem_addr, mem_wdata, mem_wstrb);
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata, mem_wstrb} !== {e.addr, e.data, e.strb}) begin
          n_fail++;
          $display("FAIL write: actual addr=%h data=%h strb=%b required addr=%h data=%h strb=%b",
                   mem_addr, mem_wdata, mem_wstrb, e.addr, e.data, e.strb);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [3:0] l, input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] n);
    start = 1'b1; layer = l; cfg_base = b; cfg_num_out = n; wb_en = 1'b0;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input int a, input int b);
    wb_en = 1'b1; groupsum_in1 = 11'(a); groupsum_in2 = 11'(b);
    tick();
  endtask

  task automatic idle(input int n);
    wb_en = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_t e;
    e.addr = a; e.data = d; e.strb = s;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    @(negedge clk);
    n_checks++;
    if ({mem_we, mem_addr, mem_wdata, mem_wstrb, busy, done, sat_flag} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: actual we=%b addr=%h data=%h strb=%b busy=%b done=%b sat=%b required all 0",
               mem_we, mem_addr, mem_wdata, mem_wstrb, busy, done, sat_flag);
    end
    rst = 1'b0;
    tick();
    do_start(4'd1, 10'h005, '0);
    beat(200, 0); beat(200, 0); beat(200, 0);
    @(negedge clk);
    n_checks++;
    if ({busy, sat_flag} !== 2'b11) begin
      n_fail++;
      $display("FAIL pre_reset_state: actual busy=%b sat=%b required busy=1 sat=1", busy, sat_flag);
    end
    rst = 1'b1; wb_en = 1'b0;
    tick();
    @(negedge clk);
    n_checks++;
    if ({mem_we, mem_addr, mem_wdata, mem_wstrb, busy, done, sat_flag} !== '0) begin
      n_fail++;
      $display("FAIL reset_midword: actual we=%b addr=%h data=%h strb=%b busy=%b done=%b sat=%b required all 0",
               mem_we, mem_addr, mem_wdata, mem_wstrb, busy, done, sat_flag);
    end
    rst = 1'b0;
    idle(6);
  endtask

  task automatic test_dual();
    do_start(4'd0, 10'h010, 16'd8);
    push(10'h010, 32'h04030201, 4'b1111);
    push(10'h011, 32'h08070605, 4'b1111);
    beat(1, 2); beat(3, 4); beat(5, 6); beat(7, 8);
    wb_en = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({mem_we, done} !== 2'b10) begin
      n_fail++;
      $display("FAIL dual_last_write: actual we=%b done=%b required we=1 done=0", mem_we, done);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if ({done, busy, mem_we} !== 3'b100) begin
      n_fail++;
      $display("FAIL dual_done: actual done=%b busy=%b we=%b required done=1 busy=0 we=0", done, busy, mem_we);
    end
    idle(3);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL dual_drain: actual pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_single_flush();
    do_start(4'd1, 10'h020, '0);
    push(10'h020, 32'h001E140A, 4'b0111);
    beat(10, 300); beat(20, -600); beat(30, 300);
    idle(1);
    @(negedge clk);
    n_checks++;
    if ({busy, mem_we, done} !== 3'b100) begin
      n_fail++;
      $display("FAIL flush_state: actual busy=%b we=%b done=%b required busy=1 we=0 done=0", busy, mem_we, done);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if ({mem_we, done, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL flush_write: actual we=%b done=%b busy=%b required we=1 done=0 busy=0", mem_we, done, busy);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if ({done, sat_flag} !== 2'b10) begin
      n_fail++;
      $display("FAIL flush_done: actual done=%b sat=%b required done=1 sat=0", done, sat_flag);
    end
    idle(3);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL flush_drain: actual pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_clamp();
    logic [31:0] exp_word;
`ifdef WB_RELU_EN
    exp_word = 32'h007F007F;
`else
    exp_word = 32'h807F807F;
`endif
    do_start(4'd1, 10'h030, 16'd4);
    push(10'h030, exp_word, 4'b1111);
    beat(500, 0); beat(-600, 0); beat(127, 0); beat(-128, 0);
    idle(3);
    @(negedge clk);
    n_checks++;
    if ({done, sat_flag} !== 2'b11) begin
      n_fail++;
      $display("FAIL clamp_flags: actual done=%b sat=%b required done=1 sat=1", done, sat_flag);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL clamp_drain: actual pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_odd_dual();
    do_start(4'd0, 10'h038, 16'd3);
    push(10'h038, 32'h00030201, 4'b0111);
    beat(1, 2); beat(3, 4); beat(5, 6);
    idle(4);
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL odd_done: actual done=%b required 1", done);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL odd_drain: actual pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_wrap();
    do_start(4'd0, 10'h3FF, 16'd8);
    push(10'h3FF, 32'h0C0B0A09, 4'b1111);
    push(10'h000, 32'h100F0E0D, 4'b1111);
    beat(9, 10); beat(11, 12); beat(13, 14); beat(15, 16);
    idle(3);
    @(negedge clk);
    n_checks++;
    if ({done, mem_addr} !== {1'b1, 10'h001}) begin
      n_fail++;
      $display("FAIL wrap_addr: actual done=%b addr=%h required done=1 addr=001", done, mem_addr);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL wrap_drain: actual pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_restart();
    do_start(4'd0, 10'h040, '0);
    beat(300, 2);
    do_start(4'd0, 10'h050, '0);
    @(negedge clk);
    n_checks++;
    if ({sat_flag, busy, mem_we, mem_addr} !== {1'b0, 1'b1, 1'b0, 10'h050}) begin
      n_fail++;
      $display("FAIL restart_run: actual sat=%b busy=%b we=%b addr=%h required sat=0 busy=1 we=0 addr=050",
               sat_flag, busy, mem_we, mem_addr);
    end
    push(10'h050, 32'h08070605, 4'b1111);
    beat(5, 6); beat(7, 8);
    idle(4);
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_done: actual done=%b required 1", done);
    end
    do_start(4'd1, 10'h060, '0);
    @(negedge clk);
    n_checks++;
    if ({done, busy, mem_addr} !== {1'b0, 1'b1, 10'h060}) begin
      n_fail++;
      $display("FAIL restart_from_done: actual done=%b busy=%b addr=%h required done=0 busy=1 addr=060",
               done, busy, mem_addr);
    end
    push(10'h060, 32'h0000002A, 4'b0001);
    beat(42, 0);
    idle(5);
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_flush_done: actual done=%b required 1", done);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL restart_drain: actual pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_dual();
    test_single_flush();
    test_clamp();
    test_odd_dual();
    test_wrap();
    test_restart();
    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
